obuf_drain: RTL and testbench

Output-buffer drain engine that sits directly downstream of the accelerator's output buffer. On a start pulse it issues one `read_o` strobe per stored row and captures the returned wide row. It then streams the row out one array column per beat over a valid/ready handshake. Each beat carries four packed COL_WIDTH-bit partial-sum lanes. Host or DMA logic therefore sees a narrow, back-pressurable result stream instead of the full `ARRAY_SIZE*4*COL_WIDTH`-bit bus.

---
 rtl/obuf_drain_if.sv | 27 ++
 rtl/obuf_drain.sv | 107 ++++++++++
 tb/tb_obuf_drain.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/obuf_drain_if.sv
// obuf_drain_if: narrow result stream leaving the output-buffer drain engine.
// The master (drain engine) drives beats and the slave (host/DMA) drives out_ready.
interface obuf_drain_if #(
    parameter int COL_WIDTH      = 13,
    parameter int LOG_ARRAY_SIZE = 3,
    parameter int LOG_DEPTH      = 5
);
    // A beat transfers on a rising clk edge where out_valid && out_ready. While
    // out_valid && !out_ready every payload field is held, and out_valid stays
    // high until the beat is taken (only rst can withdraw it).
    logic [4*COL_WIDTH-1:0]    out_data;
    logic [LOG_ARRAY_SIZE-1:0] out_col;
    logic [LOG_DEPTH-1:0]      out_row;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output out_data, out_col, out_row, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_col, out_row, out_last, out_valid,
        output out_ready
    );
endinterface

// File: rtl/obuf_drain.sv
// obuf_drain: reads output-buffer rows and streams them one column (4 psum lanes) per beat.
// Define OBUF_DRAIN_RELU_EN to clamp negative lanes to zero on out_data.
module obuf_drain #(
    parameter int ARRAY_SIZE     = 8,
    parameter int LOG_ARRAY_SIZE = 3,
    parameter int COL_WIDTH      = 10 + LOG_ARRAY_SIZE,
    parameter int LOG_DEPTH      = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [LOG_DEPTH:0]               num_rows,
    output logic                             read_o,
    input  logic [ARRAY_SIZE*4*COL_WIDTH-1:0] obuf_out,
    obuf_drain_if.master                     out_if,
    output logic                             busy,
    output logic                             done,
    output logic [2:0]                       dbg_state
);
    localparam int BEAT_W = 4 * COL_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_CAPT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [LOG_DEPTH:0]        num_lat;
    logic [LOG_DEPTH-1:0]      row;
    logic [LOG_ARRAY_SIZE-1:0] col;
    logic [BEAT_W-1:0]         hold [ARRAY_SIZE];
    logic [BEAT_W-1:0]         beat_raw;
    logic                      fire;
    logic                      last_col;
    logic                      last_row;

    assign fire     = (state == S_SEND) && out_if.out_ready;
    assign last_col = (col == LOG_ARRAY_SIZE'(ARRAY_SIZE - 1));
    assign last_row = ({1'b0, row} == (num_lat - (LOG_DEPTH+1)'(1)));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (num_rows != '0) ? S_READ : S_DONE;
            S_READ:  state_nxt = S_CAPT;
            S_CAPT:  state_nxt = S_SEND;
            S_SEND:  if (fire && last_col) state_nxt = last_row ? S_DONE : S_READ;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Row count, beat position and the captured row; obuf_out is valid in CAPT.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_lat <= '0;
            row     <= '0;
            col     <= '0;
            for (int i = 0; i < ARRAY_SIZE; i++) hold[i] <= '0;
        end else begin
            if (state == S_IDLE && start && num_rows != '0) begin
                num_lat <= num_rows;
                row     <= '0;
                col     <= '0;
            end
            if (state == S_CAPT) begin
                for (int i = 0; i < ARRAY_SIZE; i++) hold[i] <= obuf_out[i*BEAT_W +: BEAT_W];
            end
            if (fire) begin
                if (last_col) begin
                    col <= '0;
                    if (!last_row) row <= row + LOG_DEPTH'(1);
                end else begin
                    col <= col + LOG_ARRAY_SIZE'(1);
                end
            end
        end
    end

    always_comb begin
        beat_raw         = hold[col];
        read_o           = (state == S_READ);
        busy             = (state != S_IDLE);
        done             = (state == S_DONE);
        dbg_state        = state;
        out_if.out_valid = (state == S_SEND);
        out_if.out_last  = (state == S_SEND) && last_col && last_row;
        out_if.out_col   = col;
        out_if.out_row   = row;
        out_if.out_data  = beat_raw;
`ifdef OBUF_DRAIN_RELU_EN
        for (int l = 0; l < 4; l++) begin
            if (beat_raw[l*COL_WIDTH + COL_WIDTH - 1]) out_if.out_data[l*COL_WIDTH +: COL_WIDTH] = '0;
        end
`else
`endif
    end
endmodule

// File: tb/tb_obuf_drain.sv
// tb_obuf_drain: random-stimulus bench for obuf_drain against a row/column beat model.
// Includes a behavioural output buffer that answers read_o one cycle later.
module tb_obuf_drain;
    localparam int AS    = 8;
    localparam int LAS   = 3;
    localparam int CW    = 13;
    localparam int LD    = 5;
    localparam int DEPTH = 32;
    localparam int DW    = 4 * CW;
    localparam int RW    = AS * DW;
    localparam int BW    = DW + LAS + LD + 1;

    // clock / reset
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LD:0]   num_rows = '0;
    logic          read_o;
    logic [RW-1:0] obuf_out;
    logic          busy;
    logic          done;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    obuf_drain_if #(.COL_WIDTH(CW), .LOG_ARRAY_SIZE(LAS), .LOG_DEPTH(LD)) out_if ();

    obuf_drain #(.ARRAY_SIZE(AS), .LOG_ARRAY_SIZE(LAS), .COL_WIDTH(CW), .LOG_DEPTH(LD)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_rows (num_rows),
        .read_o   (read_o),
        .obuf_out (obuf_out),
        .out_if   (out_if),
        .busy     (busy),
        .done     (done),
        .dbg_state(dbg_state)
    );

    // output buffer: read pointer advances on read_o, data appears next cycle
    logic [RW-1:0] mem [DEPTH];
    logic [LD-1:0] buf_ptr;

    always @(posedge clk) begin
        if (rst) begin
            buf_ptr  <= '0;
            obuf_out <= '0;
        end else if (read_o) begin
            obuf_out <= mem[buf_ptr];
            buf_ptr  <= buf_ptr + LD'(1);
        end
    end

    // consumer ready: 0 = always, 1 = toggle 1/0, 2 = random
    int ready_mode = 0;
    bit rdy_tog = 1'b0;
    always @(posedge clk) begin
        #1;
        rdy_tog = ~rdy_tog;
        case (ready_mode)
            0:       out_if.out_ready = 1'b1;
            1:       out_if.out_ready = rdy_tog;
            default: out_if.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // scoreboard
    int n_vec = 0;
    int n_err = 0;
    logic [BW-1:0] exp_q[$];
    int exp_ptr = 0;
    int rd_cnt = 0;
    int beat_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] clamp(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
`ifdef OBUF_DRAIN_RELU_EN
        for (int l = 0; l < 4; l++) if ($signed(d[l*CW +: CW]) < 0) r[l*CW +: CW] = '0;
`endif
        return r;
    endfunction

    function automatic logic [BW-1:0] model_beat(input int mrow, input int c, input int r, input int n);
        logic [RW-1:0] rowv;
        logic [DW-1:0] d;
        rowv = mem[mrow];
        d    = clamp(rowv[c*DW +: DW]);
        return {d, 3'(c), 5'(r), 1'(c == AS - 1 && r == n - 1)};
    endfunction

    // monitor: accepted beats, stall stability, read strobe spacing
    bit            prev_read = 1'b0;
    bit            stall_pending = 1'b0;
    logic [BW-1:0] stall_beat;
    logic [BW-1:0] cur;

    always @(negedge clk) begin
        if (rst) begin
            prev_read     = 1'b0;
            stall_pending = 1'b0;
        end else begin
            cur = {out_if.out_data, out_if.out_col, out_if.out_row, out_if.out_last};
            if (read_o) begin
                rd_cnt++;
                check_val("read_gap", 64'(prev_read), 0);
            end
            prev_read = read_o;
            if (stall_pending) begin
                check_val("stall_valid", 64'(out_if.out_valid), 1);
                check_val("stall_hold", 64'(cur), 64'(stall_beat));
            end
            if (out_if.out_valid) begin
                if (out_if.out_ready) begin
                    beat_cnt++;
                    if (exp_q.size() == 0) check_val("extra_beat", 64'(cur), 0);
                    else check_val("beat", 64'(cur), 64'(exp_q.pop_front()));
                end
                stall_pending = !out_if.out_ready;
                stall_beat    = cur;
            end else begin
                stall_pending = 1'b0;
            end
        end
    end

    task automatic push_expected(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < AS; c++)
                exp_q.push_back(model_beat((exp_ptr + r) % DEPTH, c, r, n));
        exp_ptr = (exp_ptr + n) % DEPTH;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        exp_ptr = 0;
        check_val("rst_read_o", 64'(read_o), 0);
        check_val("rst_valid", 64'(out_if.out_valid), 0);
        check_val("rst_last", 64'(out_if.out_last), 0);
        check_val("rst_busy", 64'(busy), 0);
        check_val("rst_done", 64'(done), 0);
        check_val("rst_data", 64'(out_if.out_data), 0);
        check_val("rst_col", 64'(out_if.out_col), 0);
        check_val("rst_row", 64'(out_if.out_row), 0);
        check_val("rst_state", 64'(dbg_state), 0);
        rst = 1'b0;
    endtask

    // driver: one complete drain of n rows
    task automatic run_drain(input int n, input int mode, input bit poke);
        int cyc, first_v, busy_cyc;
        bit got_done;
        ready_mode = mode;
        @(negedge clk);
        push_expected(n);
        rd_cnt   = 0;
        beat_cnt = 0;
        start    = 1'b1;
        num_rows = (LD+1)'(n);
        @(posedge clk);
        #1;
        start    = 1'b0;
        num_rows = (LD+1)'($urandom);
        cyc = 0; first_v = 0; busy_cyc = 0; got_done = 1'b0;
        while (!got_done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
            if (out_if.out_valid && first_v == 0) first_v = cyc;
            if (cyc == 1) check_val("read_t1", 64'(read_o), 64'(n > 0));
            if (done) got_done = 1'b1;
            start = poke && (cyc == 4);
            if (start) num_rows = (LD+1)'($urandom_range(1, 32));
        end
        start = 1'b0;
        check_val("done_seen", 64'(got_done), 1);
        if (mode == 0) check_val("drain_cycles", cyc, n * (AS + 2) + 1);
        check_val("first_valid", first_v, (n > 0) ? 3 : 0);
        check_val("busy_span", busy_cyc, cyc);
        @(negedge clk);
        check_val("done_pulse", 64'(done), 0);
        check_val("busy_fall", 64'(busy), 0);
        check_val("read_count", rd_cnt, n);
        check_val("beat_count", beat_cnt, n * AS);
        check_val("exp_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int i = 0; i < DEPTH; i++)
            for (int w = 0; w < RW / 32; w++) mem[i][w*32 +: 32] = $urandom;
        for (int c = 0; c < AS; c++)
            for (int l = 0; l < 4; l++) begin
                mem[0][c*DW + l*CW +: CW] = CW'(c + l);
                mem[1][c*DW + l*CW +: CW] = (l % 2 == 0) ? 13'h1FFF : 13'h0FFF;
            end

        reset_dut();
        run_drain(1, 0, 1'b0);   // single row pattern
        run_drain(1, 0, 1'b0);   // -1 / 0x0FFF lanes
        run_drain(3, 1, 1'b0);   // back-pressure 1,0
        run_drain(0, 0, 1'b0);   // zero rows
        run_drain(32, 0, 1'b0);  // full depth wrap
        for (int k = 0; k < 4; k++) run_drain($urandom_range(1, 6), 2, 1'b1);

        // abort during row 1 beat 3
        ready_mode = 0;
        @(negedge clk);
        push_expected(3);
        start = 1'b1;
        num_rows = 3;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (out_if.out_valid && out_if.out_row == 1 && out_if.out_col == 3) found = 1'b1;
        end
        check_val("mid_reached", 64'(found), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_ptr = 0;
        check_val("abort_state", 64'(dbg_state), 0);
        check_val("abort_valid", 64'(out_if.out_valid), 0);
        check_val("abort_data", 64'(out_if.out_data), 0);
        check_val("abort_col", 64'(out_if.out_col), 0);
        check_val("abort_row", 64'(out_if.out_row), 0);
        check_val("abort_done", 64'(done), 0);
        check_val("abort_busy", 64'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        run_drain(1, 0, 1'b0);   // row 0 again after pointer reset

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
